code_memory_loader: RTL and testbench

Writes a program image into the 512 x 16-bit code memory from a byte stream (e.g. a UART receiver) before the CPU runs. It sits on the write side of code memory, opposite the instruction fetch path that reads it. Bytes arrive big-endian, high byte first, and are packed into 16-bit words. Words are written to sequential addresses starting at 0, and the loader signals completion.

---
 rtl/code_memory_pkg.sv | 16 +
 rtl/code_memory_loader.sv | 118 +++++++++++
 tb/tb_code_memory_loader.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_memory_pkg.sv
// Shared constants and loader state encoding for the code memory write path.
package code_memory_pkg;

    localparam int unsigned CODE_ADDR_WIDTH = 9;
    localparam int unsigned CODE_DATA_WIDTH = 16;
    localparam int unsigned CODE_DEPTH      = 512;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/code_memory_loader.sv
// Packs a big-endian byte stream into 16-bit words and writes them to code
// memory at sequential addresses from 0, then reports completion.
module code_memory_loader
    import code_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CODE_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = CODE_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_start,
    input  logic [9:0]            in_word_count,
    input  logic [7:0]            in_byte,
    input  logic                  in_byte_valid,
    output logic                  out_byte_ready,
    output logic                  out_we,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_busy,
    output logic                  out_done
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    loader_state_t         state;
    loader_state_t         state_next;
    logic [ADDR_WIDTH:0]   words_left;
    logic [ADDR_WIDTH:0]   count_clamped;
    logic [7:0]            hi_byte;
    logic                  start_ok;
    logic                  last_word;

    always_comb begin
        if (32'(in_word_count) > DEPTH) begin
            count_clamped = (ADDR_WIDTH + 1)'(DEPTH);
        end else begin
            count_clamped = (ADDR_WIDTH + 1)'(in_word_count);
        end
    end

    assign start_ok  = in_start && (state == IDLE || state == DONE) && (in_word_count != '0);
    assign last_word = (words_left == (ADDR_WIDTH + 1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every handshake-facing output is decoded from state alone, so ready never
    // depends combinationally on in_byte_valid.
    always_comb begin
        state_next     = state;
        out_byte_ready = 1'b0;
        out_we         = 1'b0;
        out_busy       = 1'b0;
        out_done       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                out_done = (state == DONE);
                if (in_start) begin
                    state_next = (in_word_count == '0) ? DONE : WAIT_HI;
                end
            end
            WAIT_HI: begin
                out_byte_ready = 1'b1;
                out_busy       = 1'b1;
                if (in_byte_valid) begin
                    state_next = WAIT_LO;
                end
            end
            WAIT_LO: begin
                out_byte_ready = 1'b1;
                out_busy       = 1'b1;
                if (in_byte_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                out_we     = 1'b1;
                out_busy   = 1'b1;
                state_next = last_word ? DONE : WAIT_HI;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The high byte is staged separately so out_data only changes when a whole
    // word is ready and otherwise holds the last written value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_left <= '0;
            out_addr   <= '0;
            out_data   <= '0;
            hi_byte    <= '0;
        end else begin
            if (start_ok) begin
                words_left <= count_clamped;
                out_addr   <= '0;
            end
            if (state == WAIT_HI && in_byte_valid) begin
                hi_byte <= in_byte;
            end
            if (state == WAIT_LO && in_byte_valid) begin
                out_data <= DATA_WIDTH'({hi_byte, in_byte});
            end
            if (state == WRITE && !last_word) begin
                words_left <= words_left - 1'b1;
                out_addr   <= out_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_code_memory_loader.sv
// Randomized bench for code_memory_loader against a byte-list word model and a
// bench-side copy of code memory.
module tb_code_memory_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_start = 1'b0;
    logic [9:0]  in_word_count = '0;
    logic [7:0]  in_byte = '0;
    logic        in_byte_valid = 1'b0;
    logic        out_byte_ready;
    logic        out_we;
    logic [8:0]  out_addr;
    logic [15:0] out_data;
    logic        out_busy;
    logic        out_done;

    code_memory_loader #(.ADDR_WIDTH(9), .DATA_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_start       (in_start),
        .in_word_count  (in_word_count),
        .in_byte        (in_byte),
        .in_byte_valid  (in_byte_valid),
        .out_byte_ready (out_byte_ready),
        .out_we         (out_we),
        .out_addr       (out_addr),
        .out_data       (out_data),
        .out_busy       (out_busy),
        .out_done       (out_done)
    );

    always #5 clk = ~clk;

    logic [15:0] code_mem [512];
    always @(posedge clk) begin
        if (out_we) code_mem[out_addr] <= out_data;
    end

    int total = 0;
    int bad = 0;

    logic [7:0]  stim [$];
    logic [8:0]  wr_addr [$];
    logic [15:0] wr_data [$];
    int first_we_cyc, last_we_cyc, done_cyc, accepted;
    logic busy_at_done, start_ready;

    function automatic logic [15:0] exp_word(input int i);
        return {stim[2*i], stim[2*i+1]};
    endfunction

    function automatic int exp_words(input int count);
        return (count > 512) ? 512 : count;
    endfunction

    // Byte source plus write monitor; a byte offered while ready is low is held.
    task automatic run_load(input int count, input int gap_pct, input bit busy_start, input int max_cycles);
        int bi = 0;
        bit hold = 0;
        bit pulsed = 0;
        wr_addr.delete();
        wr_data.delete();
        first_we_cyc = -1;
        last_we_cyc = -1;
        done_cyc = -1;
        busy_at_done = 1'bx;
        @(negedge clk);
        in_word_count = 10'(count);
        in_start = 1'b1;
        in_byte_valid = 1'b0;
        @(negedge clk);
        in_start = 1'b0;
        start_ready = out_byte_ready;
        for (int cyc = 1; cyc <= max_cycles; cyc++) begin
            if (out_we) begin
                wr_addr.push_back(out_addr);
                wr_data.push_back(out_data);
                if (first_we_cyc < 0) first_we_cyc = cyc;
                last_we_cyc = cyc;
            end
            if (out_done) begin
                done_cyc = cyc;
                busy_at_done = out_busy;
                break;
            end
            in_start = 1'b0;
            if (busy_start && !pulsed && out_byte_ready && (bi % 2 == 1)) begin
                in_start = 1'b1;
                in_word_count = 10'd1;
                pulsed = 1;
            end
            if (!hold) begin
                if (bi < stim.size() && $urandom_range(99) >= gap_pct) begin
                    in_byte_valid = 1'b1;
                    in_byte = stim[bi];
                end else begin
                    in_byte_valid = 1'b0;
                end
            end
            hold = in_byte_valid && !out_byte_ready;
            if (in_byte_valid && out_byte_ready) bi++;
            @(negedge clk);
        end
        in_start = 1'b0;
        in_byte_valid = 1'b0;
        accepted = bi;
    endtask

    task automatic fill_stim(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'($urandom_range(255)));
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++; if (out_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", out_we); end
            total++; if (out_addr !== 9'd0) begin bad++; $display("FAIL reset_addr: got %0h want 0", out_addr); end
            total++; if (out_data !== 16'd0) begin bad++; $display("FAIL reset_data: got %0h want 0", out_data); end
            total++; if (out_byte_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", out_byte_ready); end
            total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", out_busy); end
            total++; if (out_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", out_done); end
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_zero_count;
        int we_seen = 0;
        int busy_seen = 0;
        stim.delete();
        run_load(0, 0, 0, 10);
        total++; if (done_cyc !== 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
        total++; if (wr_addr.size() !== 0) begin bad++; $display("FAIL zero_writes: got %0d want 0", wr_addr.size()); end
        total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy_at_done); end
        for (int i = 0; i < 4; i++) begin
            if (out_we) we_seen++;
            if (out_busy) busy_seen++;
            @(negedge clk);
        end
        total++; if (we_seen + busy_seen !== 0) begin bad++; $display("FAIL zero_idle: got we=%0d busy=%0d want 0", we_seen, busy_seen); end
    endtask

    task automatic test_two_words;
        stim.delete();
        stim.push_back(8'hF0); stim.push_back(8'hF0);
        stim.push_back(8'h0F); stim.push_back(8'h0F);
        run_load(2, 0, 0, 50);
        total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL two_start_latency: got %b want 1", start_ready); end
        total++; if (wr_addr.size() !== 2) begin bad++; $display("FAIL two_write_count: got %0d want 2", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 2; i++) begin
            total++; if (wr_addr[i] !== 9'(i) || wr_data[i] !== exp_word(i)) begin
                bad++; $display("FAIL two_write%0d: got %0h@%0d want %0h@%0d", i, wr_data[i], wr_addr[i], exp_word(i), i);
            end
        end
        total++; if (first_we_cyc !== 3) begin bad++; $display("FAIL two_first_we: got %0d want 3", first_we_cyc); end
        total++; if (last_we_cyc !== 6) begin bad++; $display("FAIL two_throughput: got %0d want 6", last_we_cyc); end
        total++; if (done_cyc !== 7) begin bad++; $display("FAIL two_done: got %0d want 7", done_cyc); end
        total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL two_busy_at_done: got %b want 0", busy_at_done); end
        total++; if (out_addr !== 9'd1 || out_data !== 16'h0F0F) begin
            bad++; $display("FAIL two_hold: got %0h@%0d want 0f0f@1", out_data, out_addr);
        end
        total++; if (code_mem[0] !== 16'hF0F0) begin bad++; $display("FAIL two_mem0: got %0h want f0f0", code_mem[0]); end
        total++; if (code_mem[1] !== 16'h0F0F) begin bad++; $display("FAIL two_mem1: got %0h want 0f0f", code_mem[1]); end
    endtask

    task automatic test_backpressure;
        logic [7:0] hi, lo;
        int extra_we = 0;
        int extra_ready = 0;
        hi = 8'($urandom_range(255));
        lo = 8'($urandom_range(255));
        @(negedge clk);
        in_byte = hi; in_byte_valid = 1'b1;
        in_word_count = 10'd1; in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        total++; if (out_byte_ready !== 1'b1) begin bad++; $display("FAIL bp_ready: got %b want 1", out_byte_ready); end
        @(negedge clk);
        in_byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        in_byte = lo; in_byte_valid = 1'b1;
        @(negedge clk);
        total++; if (out_we !== 1'b1 || out_addr !== 9'd0 || out_data !== {hi, lo}) begin
            bad++; $display("FAIL bp_write: got we=%b %0h@%0d want we=1 %0h@0", out_we, out_data, out_addr, {hi, lo});
        end
        in_byte = 8'($urandom_range(255));
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (out_we) extra_we++;
            if (out_byte_ready) extra_ready++;
            @(negedge clk);
        end
        total++; if (extra_we + extra_ready !== 0) begin bad++; $display("FAIL bp_extra: got we=%0d ready=%0d want 0", extra_we, extra_ready); end
        total++; if (out_done !== 1'b1) begin bad++; $display("FAIL bp_done: got %b want 1", out_done); end
        in_byte_valid = 1'b0;
    endtask

    task automatic test_full_depth;
        int errs = 0;
        int leak = 0;
        fill_stim(1024);
        run_load(1023, 0, 0, 2000);
        total++; if (wr_addr.size() !== exp_words(1023)) begin bad++; $display("FAIL full_count: got %0d want %0d", wr_addr.size(), exp_words(1023)); end
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] !== 9'(i) || wr_data[i] !== exp_word(i)) begin
                errs++;
                if (errs < 4) $display("FAIL full_write%0d: got %0h@%0d want %0h@%0d", i, wr_data[i], wr_addr[i], exp_word(i), i);
            end
        end
        total++; if (errs != 0) bad++;
        total++; if (out_addr !== 9'd511) begin bad++; $display("FAIL full_last_addr: got %0d want 511", out_addr); end
        total++; if (done_cyc !== 1537) begin bad++; $display("FAIL full_done: got %0d want 1537", done_cyc); end
        total++; if (accepted !== 1024) begin bad++; $display("FAIL full_accepted: got %0d want 1024", accepted); end
        in_byte_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_byte_ready || out_we) leak++;
            @(negedge clk);
        end
        in_byte_valid = 1'b0;
        total++; if (leak !== 0) begin bad++; $display("FAIL full_extra_bytes: got %0d want 0", leak); end
    endtask

    task automatic test_start_while_busy;
        fill_stim(6);
        run_load(3, 0, 1, 60);
        total++; if (wr_addr.size() !== 3) begin bad++; $display("FAIL busy_count: got %0d want 3", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 3; i++) begin
            total++; if (wr_addr[i] !== 9'(i) || wr_data[i] !== exp_word(i)) begin
                bad++; $display("FAIL busy_write%0d: got %0h@%0d want %0h@%0d", i, wr_data[i], wr_addr[i], exp_word(i), i);
            end
        end
        total++; if (done_cyc !== 10) begin bad++; $display("FAIL busy_done: got %0d want 10", done_cyc); end
    endtask

    task automatic test_reset_mid_load;
        int n = 0;
        fill_stim(8);
        wr_addr.delete();
        wr_data.delete();
        @(negedge clk);
        in_word_count = 10'd4; in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            if (out_we) begin wr_addr.push_back(out_addr); wr_data.push_back(out_data); end
            in_byte_valid = 1'b1;
            in_byte = stim[n];
            if (out_byte_ready) n++;
            @(negedge clk);
        end
        in_byte_valid = 1'b0;
        total++; if (n !== 3 || wr_addr.size() !== 1) begin bad++; $display("FAIL rst_progress: got bytes=%0d writes=%0d want 3/1", n, wr_addr.size()); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({out_we, out_byte_ready, out_busy, out_done} !== 4'b0) begin
            bad++; $display("FAIL rst_async_flags: got %b want 0000", {out_we, out_byte_ready, out_busy, out_done});
        end
        total++; if (out_addr !== 9'd0 || out_data !== 16'd0) begin
            bad++; $display("FAIL rst_async_bus: got %0h@%0d want 0@0", out_data, out_addr);
        end
        total++; if (code_mem[0] !== exp_word(0)) begin bad++; $display("FAIL rst_word0_kept: got %0h want %0h", code_mem[0], exp_word(0)); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fill_stim(4);
        run_load(2, 30, 0, 200);
        total++; if (wr_addr.size() !== 2) begin bad++; $display("FAIL rst_reload_count: got %0d want 2", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 2; i++) begin
            total++; if (wr_addr[i] !== 9'(i) || wr_data[i] !== exp_word(i)) begin
                bad++; $display("FAIL rst_reload%0d: got %0h@%0d want %0h@%0d", i, wr_data[i], wr_addr[i], exp_word(i), i);
            end
        end
    endtask

    task automatic test_random_loads;
        int count;
        int errs;
        for (int it = 0; it < 6; it++) begin
            count = $urandom_range(24, 1);
            fill_stim(2 * count);
            run_load(count, 50, 0, 20 * count + 50);
            errs = 0;
            if (wr_addr.size() !== count) errs++;
            for (int i = 0; i < wr_addr.size() && i < count; i++) begin
                if (wr_addr[i] !== 9'(i) || wr_data[i] !== exp_word(i)) errs++;
            end
            total++; if (errs != 0) begin
                bad++; $display("FAIL rand%0d_writes: got %0d writes (%0d bad) want %0d", it, wr_addr.size(), errs, count);
            end
            total++; if (done_cyc < 0 || done_cyc !== last_we_cyc + 1 || busy_at_done !== 1'b0) begin
                bad++; $display("FAIL rand%0d_done: got done=%0d busy=%b want %0d busy=0", it, done_cyc, busy_at_done, last_we_cyc + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_count();
        test_two_words();
        test_backpressure();
        test_full_depth();
        test_start_while_busy();
        test_reset_mid_load();
        test_random_loads();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
